ram_dp_clr: RTL and testbench

RAM_DP_CLR -- requirements
Module: ram_dp_clr

---
 rtl/ram_dp_clr.sv | 151 +++++++++++++++
 tb/tb_ram_dp_clr.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_dp_clr.sv
// ram_dp_clr: simple dual-port RAM with per-lane write enables, a one-cycle
// registered read port and a hardware zero-fill engine.
//
// Ports:
//   clk     - single clock, all state changes on its rising edge
//   reset_n - asynchronous active-low reset (starts a zero fill on release)
//   clear   - pulse requesting a full-memory zero fill (ignored while busy)
//   busy    - high while the zero fill runs
//   we      - write enable
//   waddr   - write address (A bits)
//   wdata   - write data (D bits)
//   wbe     - per-lane write enables, bit i covers wdata[i*W +: W]
//   re      - read enable
//   raddr   - read address (A bits)
//   rdata   - registered read data, holds when no read completes
//   rvalid  - one-cycle pulse marking fresh rdata
module ram_dp_clr #(
  parameter int A   = 10,
  parameter int D   = 8,
  parameter int W   = 8,
  parameter int RDW = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  output logic             busy,
  input  logic             we,
  input  logic [A-1:0]     waddr,
  input  logic [D-1:0]     wdata,
  input  logic [D/W-1:0]   wbe,
  input  logic             re,
  input  logic [A-1:0]     raddr,
  output logic [D-1:0]     rdata,
  output logic             rvalid
);

  localparam int L     = D / W;
  localparam int DEPTH = 1 << A;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t         state_r;
  state_t         state_s;
  logic [A-1:0]   cnt_r;
  logic [A-1:0]   cnt_s;
  logic           busy_r;
  logic [D-1:0]   rdata_r;
  logic           rvalid_r;
  logic [D-1:0]   mem_r [0:DEPTH-1];
  logic           idle_s;

  // Lane merge: enabled lanes take the new word, the rest keep the old one.
  function automatic logic [D-1:0] merge_lanes(
    input logic [D-1:0] old_word,
    input logic [D-1:0] new_word,
    input logic [L-1:0] lane_en
  );
    logic [D-1:0] res;
    res = old_word;
    for (int i = 0; i < L; i++) begin
      if (lane_en[i]) begin
        res[i*W +: W] = new_word[i*W +: W];
      end else begin
        res[i*W +: W] = old_word[i*W +: W];
      end
    end
    return res;
  endfunction

  assign idle_s = (state_r == IDLE);

  // Fill FSM next-state: IDLE waits for clear, CLEAR walks cnt over every word.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (clear) begin
          state_s = CLEAR;
          cnt_s   = {A{1'b0}};
        end else begin
          state_s = IDLE;
          cnt_s   = cnt_r;
        end
      end
      CLEAR: begin
        // clear is deliberately not looked at here: no restart mid-fill
        cnt_s = cnt_r + A'(1'b1);
        if (cnt_r == {A{1'b1}}) begin
          state_s = IDLE;
        end else begin
          state_s = CLEAR;
        end
      end
      default: begin
        state_s = CLEAR;
        cnt_s   = {A{1'b0}};
      end
    endcase
  end

  // FSM state, fill counter and busy flag; reset parks the block in CLEAR.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= CLEAR;
      cnt_r   <= {A{1'b0}};
      busy_r  <= 1'b1;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      // registered copy of (state == CLEAR), kept in step with state_r
      busy_r  <= (state_s == CLEAR);
    end
  end

  // Memory array: fill writes zero, user writes merge enabled lanes. No reset.
  always_ff @(posedge clk) begin
    if (reset_n && (state_r == CLEAR)) begin
      mem_r[cnt_r] <= {D{1'b0}};
    end else if (idle_s && we) begin
      mem_r[waddr] <= merge_lanes(mem_r[waddr], wdata, wbe);
    end
  end

  // Read port: one-cycle latency; on a same-address collision the write
  // has not landed yet, so write-through mode merges the new lanes here.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_r  <= {D{1'b0}};
      rvalid_r <= 1'b0;
    end else if (idle_s && re) begin
      if ((RDW == 1) && we && (waddr == raddr)) begin
        rdata_r <= merge_lanes(mem_r[raddr], wdata, wbe);
      end else begin
        rdata_r <= mem_r[raddr];
      end
      rvalid_r <= 1'b1;
    end else begin
      rdata_r  <= rdata_r;
      rvalid_r <= 1'b0;
    end
  end

  assign busy   = busy_r;
  assign rdata  = rdata_r;
  assign rvalid = rvalid_r;

endmodule

// File: tb/tb_ram_dp_clr.sv
// tb_ram_dp_clr: directed self-checking bench for ram_dp_clr.
// dut0: A=4, D=8, W=8, RDW=0 (old data on collision)
// dut1: A=4, D=16, W=8, RDW=1 (write-through, two byte lanes)
module tb_ram_dp_clr;

  logic        clk = 1'b0;
  logic        reset_n;

  logic        clear0, we0, re0, busy0, rvalid0;
  logic [3:0]  waddr0, raddr0;
  logic [7:0]  wdata0, rdata0;
  logic [0:0]  wbe0;

  logic        clear1, we1, re1, busy1, rvalid1;
  logic [3:0]  waddr1, raddr1;
  logic [15:0] wdata1, rdata1;
  logic [1:0]  wbe1;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  ram_dp_clr #(.A(4), .D(8), .W(8), .RDW(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .clear(clear0), .busy(busy0),
    .we(we0), .waddr(waddr0), .wdata(wdata0), .wbe(wbe0),
    .re(re0), .raddr(raddr0), .rdata(rdata0), .rvalid(rvalid0)
  );

  ram_dp_clr #(.A(4), .D(16), .W(8), .RDW(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .clear(clear1), .busy(busy1),
    .we(we1), .waddr(waddr1), .wdata(wdata1), .wbe(wbe1),
    .re(re1), .raddr(raddr1), .rdata(rdata1), .rvalid(rvalid1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    clear0 = 1'b0; we0 = 1'b0; re0 = 1'b0; waddr0 = 4'd0; raddr0 = 4'd0;
    wdata0 = 8'h00; wbe0 = 1'b0;
    clear1 = 1'b0; we1 = 1'b0; re1 = 1'b0; waddr1 = 4'd0; raddr1 = 4'd0;
    wdata1 = 16'h0000; wbe1 = 2'b00;
  endtask

  task automatic test_reset();
    int cyc;
    reset_n = 1'b0;
    idle_inputs();
    tick(); tick();
    total_cnt++;
    if (busy0 !== 1'b1 || rvalid0 !== 1'b0 || rdata0 !== 8'h00 || busy1 !== 1'b1)
      $display("FAIL reset_state: busy0=%b rvalid0=%b rdata0=%h busy1=%b, required 1 0 00 1",
               busy0, rvalid0, rdata0, busy1);
    else pass_cnt++;
    reset_n = 1'b1;
    cyc = 0;
    while (busy0 === 1'b1 && cyc < 40) begin
      cyc++;
      tick();
    end
    total_cnt++;
    if (cyc !== 16) $display("FAIL reset_fill_len: busy cycles=%0d, required 16", cyc);
    else pass_cnt++;
    total_cnt++;
    if (busy1 !== 1'b0) $display("FAIL reset_fill_dut1: busy1=%b, required 0", busy1);
    else pass_cnt++;
  endtask

  task automatic test_read_all_zero(input string tag);
    for (int a = 0; a < 16; a++) begin
      re0 = 1'b1; raddr0 = 4'(a);
      tick();
      total_cnt++;
      if (rvalid0 !== 1'b1 || rdata0 !== 8'h00)
        $display("FAIL %s addr %0d: rvalid=%b rdata=%h, required 1 00", tag, a, rvalid0, rdata0);
      else pass_cnt++;
    end
    re0 = 1'b0;
  endtask

  task automatic test_write_read();
    we0 = 1'b1; waddr0 = 4'd3; wdata0 = 8'hA5; wbe0 = 1'b1;
    tick();
    we0 = 1'b0; re0 = 1'b1; raddr0 = 4'd3;
    tick();
    total_cnt++;
    if (rdata0 !== 8'hA5 || rvalid0 !== 1'b1)
      $display("FAIL read_a5: rdata=%h rvalid=%b, required a5 1", rdata0, rvalid0);
    else pass_cnt++;
    re0 = 1'b0;
    tick();
    total_cnt++;
    if (rdata0 !== 8'hA5 || rvalid0 !== 1'b0)
      $display("FAIL read_hold: rdata=%h rvalid=%b, required a5 0", rdata0, rvalid0);
    else pass_cnt++;
    // wbe=0 and we=0 must both leave the word alone
    we0 = 1'b1; waddr0 = 4'd3; wdata0 = 8'h00; wbe0 = 1'b0;
    tick();
    we0 = 1'b0; wdata0 = 8'hFF; wbe0 = 1'b1;
    tick();
    re0 = 1'b1; raddr0 = 4'd3;
    tick();
    re0 = 1'b0;
    total_cnt++;
    if (rdata0 !== 8'hA5) $display("FAIL no_write: rdata=%h, required a5", rdata0);
    else pass_cnt++;
    // top address
    we0 = 1'b1; waddr0 = 4'd15; wdata0 = 8'h5A; wbe0 = 1'b1;
    tick();
    we0 = 1'b0; re0 = 1'b1; raddr0 = 4'd15;
    tick();
    re0 = 1'b0;
    total_cnt++;
    if (rdata0 !== 8'h5A) $display("FAIL top_addr: rdata=%h, required 5a", rdata0);
    else pass_cnt++;
  endtask

  task automatic test_byte_lanes();
    we1 = 1'b1; waddr1 = 4'd5; wdata1 = 16'h1234; wbe1 = 2'b11;
    tick();
    wdata1 = 16'hABCD; wbe1 = 2'b10;
    tick();
    we1 = 1'b0; re1 = 1'b1; raddr1 = 4'd5;
    tick();
    total_cnt++;
    if (rdata1 !== 16'hAB34) $display("FAIL lane_hi: rdata=%h, required ab34", rdata1);
    else pass_cnt++;
    re1 = 1'b0; we1 = 1'b1; wdata1 = 16'h55EE; wbe1 = 2'b01;
    tick();
    we1 = 1'b0; re1 = 1'b1;
    tick();
    re1 = 1'b0;
    total_cnt++;
    if (rdata1 !== 16'hABEE) $display("FAIL lane_lo: rdata=%h, required abee", rdata1);
    else pass_cnt++;
  endtask

  task automatic test_collision();
    we0 = 1'b1; waddr0 = 4'd9; wdata0 = 8'h11; wbe0 = 1'b1;
    we1 = 1'b1; waddr1 = 4'd9; wdata1 = 16'h0011; wbe1 = 2'b11;
    tick();
    wdata0 = 8'h77; re0 = 1'b1; raddr0 = 4'd9;
    wdata1 = 16'h0077; re1 = 1'b1; raddr1 = 4'd9;
    tick();
    we0 = 1'b0; we1 = 1'b0;
    total_cnt++;
    if (rdata0 !== 8'h11) $display("FAIL rdw_old: rdata=%h, required 11", rdata0);
    else pass_cnt++;
    total_cnt++;
    if (rdata1 !== 16'h0077) $display("FAIL rdw_new: rdata=%h, required 0077", rdata1);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (rdata0 !== 8'h77) $display("FAIL rdw_after: rdata=%h, required 77", rdata0);
    else pass_cnt++;
    // write-through with one lane enabled returns the merged word
    we1 = 1'b1; wdata1 = 16'hAAFF; wbe1 = 2'b10;
    tick();
    we1 = 1'b0; re0 = 1'b0; re1 = 1'b0;
    total_cnt++;
    if (rdata1 !== 16'hAA77) $display("FAIL rdw_merge: rdata=%h, required aa77", rdata1);
    else pass_cnt++;
  endtask

  task automatic test_independent();
    we0 = 1'b1; waddr0 = 4'd4; wdata0 = 8'h3C; wbe0 = 1'b1;
    re0 = 1'b1; raddr0 = 4'd3;
    tick();
    we0 = 1'b0; raddr0 = 4'd4;
    total_cnt++;
    if (rdata0 !== 8'hA5) $display("FAIL indep_read: rdata=%h, required a5", rdata0);
    else pass_cnt++;
    tick();
    re0 = 1'b0;
    total_cnt++;
    if (rdata0 !== 8'h3C) $display("FAIL indep_write: rdata=%h, required 3c", rdata0);
    else pass_cnt++;
  endtask

  task automatic test_clear();
    int cyc;
    logic bad_rv;
    clear0 = 1'b1;
    tick();
    clear0 = 1'b0;
    we0 = 1'b1; waddr0 = 4'd2; wdata0 = 8'hFF; wbe0 = 1'b1;
    re0 = 1'b1; raddr0 = 4'd3;
    cyc = 0;
    bad_rv = 1'b0;
    while (busy0 === 1'b1 && cyc < 40) begin
      cyc++;
      clear0 = (cyc == 7) ? 1'b1 : 1'b0;
      tick();
      if (rvalid0 !== 1'b0) bad_rv = 1'b1;
    end
    idle_inputs();
    total_cnt++;
    if (cyc !== 16) $display("FAIL clear_len: busy cycles=%0d, required 16", cyc);
    else pass_cnt++;
    total_cnt++;
    if (bad_rv !== 1'b0) $display("FAIL clear_no_rvalid: rvalid seen=%b, required 0", bad_rv);
    else pass_cnt++;
    test_read_all_zero("clear_zero");
  endtask

  task automatic test_reset_mid_fill();
    int cyc;
    we0 = 1'b1; waddr0 = 4'd3; wdata0 = 8'hA5; wbe0 = 1'b1;
    tick();
    we0 = 1'b0; re0 = 1'b1; raddr0 = 4'd3;
    tick();
    re0 = 1'b0; clear0 = 1'b1;
    tick();
    clear0 = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    reset_n = 1'b0;
    #1;
    total_cnt++;
    if (busy0 !== 1'b1 || rvalid0 !== 1'b0 || rdata0 !== 8'h00)
      $display("FAIL midfill_reset: busy=%b rvalid=%b rdata=%h, required 1 0 00",
               busy0, rvalid0, rdata0);
    else pass_cnt++;
    tick(); tick();
    reset_n = 1'b1;
    cyc = 0;
    while (busy0 === 1'b1 && cyc < 40) begin
      cyc++;
      tick();
    end
    total_cnt++;
    if (cyc !== 16) $display("FAIL midfill_len: busy cycles=%0d, required 16", cyc);
    else pass_cnt++;
    re0 = 1'b1; raddr0 = 4'd3;
    tick();
    re0 = 1'b0;
    total_cnt++;
    if (rdata0 !== 8'h00 || rvalid0 !== 1'b1)
      $display("FAIL midfill_zero: rdata=%h rvalid=%b, required 00 1", rdata0, rvalid0);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_read_all_zero("init_zero");
    test_write_read();
    test_byte_lanes();
    test_collision();
    test_independent();
    test_clear();
    test_reset_mid_fill();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
